// File: rtl/pkt_pkg.sv
// Shared definitions for the packet transmit framer: widths, header field
// offsets, FSM state encoding, command record and header builder.
package pkt_pkg;

  localparam int W     = 64;
  localparam int LEN_W = 16;

  // Header flit layout
  localparam int DST_HI   = 63;
  localparam int DST_LO   = 56;
  localparam int LEN_HI   = 55;
  localparam int LEN_LO   = 40;
  localparam int FLAG_TRL = 39;
  localparam int TAG_HI   = 31;
  localparam int TAG_LO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TRL  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [7:0]       dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      tag;
  } tx_cmd_t;

  function automatic logic [W-1:0] make_hdr(
    input logic [7:0]       dst,
    input logic [LEN_W-1:0] len,
    input logic [31:0]      tag,
    input logic             trl
  );
    logic [W-1:0] h;
    h                 = '0;
    h[DST_HI:DST_LO]  = dst;
    h[LEN_HI:LEN_LO]  = len;
    h[FLAG_TRL]       = trl;
    h[TAG_HI:TAG_LO]  = tag;
    return h;
  endfunction

endpackage

// File: rtl/pkt_tx_fifo.sv
// Payload FIFO, depth 2^AW. The head word is presented straight from the
// register array so the framer can capture it into its output register on
// the same edge it pops. A push into a full FIFO with no concurrent pop is
// dropped and flagged by the ERR_OVF assertion.
module pkt_tx_fifo #(
  parameter int DW = 64,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // a pop frees a slot this cycle, so a push alongside it is always safe
  assign w_push = wr_en & (~full | rd_en);
  assign w_pop  = rd_en & ~empty;

  // storage array, written on accepted push (no reset needed)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  ERR_OVF: assert property (@(posedge clk) disable iff (!rst_n)
                            !(wr_en && full && !rd_en));

endmodule

// File: rtl/pkt_tx_framer.sv
// Packet transmit framer: takes a command (dst/len/tag) and buffered payload
// words, emits header + LEN payload flits to a router port while honouring
// the router's one-cycle backpressure. Payload is decoupled from router
// backpressure through pkt_tx_fifo; the PE only sees D_BP.
// Optional checksum trailer flit: define PKT_TX_TRAILER_EN.
module pkt_tx_framer import pkt_pkg::*; #(
  parameter int FIFO_AW   = 4,
  parameter int BP_MARGIN = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [7:0]       CMD_DST,
  input  logic [LEN_W-1:0] CMD_LEN,
  input  logic [31:0]      CMD_TAG,
  input  logic [W-1:0]     D,
  input  logic             D_VALID,
  output logic             D_BP,
  output logic [W-1:0]     Q,
  output logic             Q_VALID,
  input  logic             Q_BP,
  output logic             BUSY
);
  localparam int DEPTH = 1 << FIFO_AW;

`ifdef PKT_TX_TRAILER_EN
  localparam logic      TRL_FLAG  = 1'b1;
  localparam tx_state_e LAST_NEXT = TRL;
`else
  localparam logic      TRL_FLAG  = 1'b0;
  localparam tx_state_e LAST_NEXT = IDLE;
`endif

  tx_state_e        r_state, w_next;
  tx_cmd_t          r_cmd;
  logic [LEN_W-1:0] r_rem;
  logic             r_run;
  logic [W-1:0]     r_q;
  logic             r_q_valid;

  logic             w_accept, w_emit_hdr, w_pop;
  logic [W-1:0]     w_hdr, w_fifo_rd;
  logic [FIFO_AW:0] w_count, w_free;
  logic             w_full, w_empty;
`ifdef PKT_TX_TRAILER_EN
  logic             w_emit_trl;
  logic [W-1:0]     r_xor;
`endif

  pkt_tx_fifo #(.DW(W), .AW(FIFO_AW)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (D_VALID),
    .wr_data (D),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_hdr  = make_hdr(r_cmd.dst, r_cmd.len, r_cmd.tag, TRL_FLAG);
  assign w_free = (FIFO_AW+1)'(DEPTH) - w_count;

  // r_run holds everything quiet until the first edge after reset release
  assign CMD_READY = r_run & (r_state == IDLE);
  assign BUSY      = (r_state != IDLE);
  assign D_BP      = ~r_run | w_full | (w_free <= (FIFO_AW+1)'(BP_MARGIN));
  assign Q         = r_q;
  assign Q_VALID   = r_q_valid;

  // state register and run flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // next state and per-cycle actions; Q_BP high at an edge blocks any flit
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_emit_hdr = 1'b0;
    w_pop      = 1'b0;
`ifdef PKT_TX_TRAILER_EN
    w_emit_trl = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (r_run && CMD_VALID) begin
          w_accept = 1'b1;
          w_next   = HDR;
        end
      end
      HDR: begin
        if (!Q_BP) begin
          w_emit_hdr = 1'b1;
          w_next     = (r_rem != '0) ? PAY : LAST_NEXT;
        end
      end
      PAY: begin
        // empty FIFO means a bubble: nothing popped, count holds
        if (!Q_BP && !w_empty) begin
          w_pop = 1'b1;
          if (r_rem == LEN_W'(1)) w_next = LAST_NEXT;
        end
      end
`ifdef PKT_TX_TRAILER_EN
      TRL: begin
        if (!Q_BP) begin
          w_emit_trl = 1'b1;
          w_next     = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // command latch and remaining payload count (leaves PAY at 1, never wraps)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cmd <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_cmd <= '{dst: CMD_DST, len: CMD_LEN, tag: CMD_TAG};
      r_rem <= CMD_LEN;
    end else if (w_pop) begin
      r_rem <= r_rem - LEN_W'(1);
    end
  end

  // registered flit output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
`ifdef PKT_TX_TRAILER_EN
      r_q_valid <= w_emit_hdr | w_pop | w_emit_trl;
      if (w_emit_hdr)      r_q <= w_hdr;
      else if (w_pop)      r_q <= w_fifo_rd;
      else if (w_emit_trl) r_q <= r_xor;
`else
      r_q_valid <= w_emit_hdr | w_pop;
      if (w_emit_hdr) r_q <= w_hdr;
      else if (w_pop) r_q <= w_fifo_rd;
`endif
    end
  end

`ifdef PKT_TX_TRAILER_EN
  // running checksum: seeded with the header, folded with each payload word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          r_xor <= '0;
    else if (w_emit_hdr) r_xor <= w_hdr;
    else if (w_pop)      r_xor <= r_xor ^ w_fifo_rd;
  end
`endif

endmodule
